// File: rtl/mac_acc_pkg.sv
// Shared types and constants for the MAC accumulator: FSM states, mode encodings, default widths.
// Saturation is selected at build time by defining MAC_ACC_SAT_EN.
package mac_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 32;
  localparam int LEN_W_DEF  = 8;

endpackage

// File: rtl/mac_acc_addsub.sv
// Combinational next-accumulator stage: unsigned add/sub of a zero-extended product with carry/borrow out.
// With MAC_ACC_SAT_EN defined the result clamps on overflow; otherwise it wraps modulo 2**ACC_W.
module mac_acc_addsub
  import mac_acc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [DATA_W-1:0] prod_i,
  input  logic              mode_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              flag_o
);

  // Clamp target: all-ones for an add carry, zero for a subtract borrow.
  function automatic logic [ACC_W-1:0] sat_val(input logic mode);
    return (mode == MODE_SUB) ? '0 : '1;
  endfunction

  logic [ACC_W:0]   ext_prod;
  logic [ACC_W:0]   sum_w;
  logic [ACC_W:0]   diff_w;
  logic [ACC_W-1:0] raw_w;

  assign ext_prod = {{(ACC_W + 1 - DATA_W){1'b0}}, prod_i};

  always_comb begin
    sum_w  = {1'b0, acc_i} + ext_prod;
    diff_w = {1'b0, acc_i} - ext_prod;
    if (mode_i == MODE_SUB) begin
      raw_w  = diff_w[ACC_W-1:0];
      flag_o = diff_w[ACC_W];
    end else begin
      raw_w  = sum_w[ACC_W-1:0];
      flag_o = sum_w[ACC_W];
    end
`ifdef MAC_ACC_SAT_EN
    acc_o = flag_o ? sat_val(mode_i) : raw_w;
`else
    acc_o = raw_w;
`endif
  end

endmodule

// File: rtl/mac_accumulator.sv
// Burst multiply-accumulate: sums or subtracts LEN products, returns one result with a sticky overflow flag.
// Define MAC_ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module mac_accumulator
  import mac_acc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              sub_mode,
  input  logic              abort,
  input  logic              prod_valid,
  input  logic [DATA_W-1:0] prod_data,
  output logic              prod_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic               mode_q, mode_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               prod_ready_q, prod_ready_d;
  logic               res_valid_q, res_valid_d;
  logic               busy_q, busy_d;

  logic [ACC_W-1:0]   acc_nxt;
  logic               acc_flag;
  logic               prod_hs;
  logic               res_hs;

  mac_acc_addsub #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_addsub (
    .acc_i  (acc_q),
    .prod_i (prod_data),
    .mode_i (mode_q),
    .acc_o  (acc_nxt),
    .flag_o (acc_flag)
  );

  assign prod_hs = prod_valid & prod_ready_q;
  assign res_hs  = res_valid_q & res_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (abort) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            mode_d  = sub_mode;
            count_d = len;
            state_d = (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (prod_hs) begin
            acc_d   = acc_nxt;
            ovf_d   = ovf_q | acc_flag;
            count_d = count_q - LEN_W'(1);
            if (count_q == LEN_W'(1)) state_d = DONE;
          end
        end
        DONE: begin
          if (res_hs) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // Handshake outputs are registered copies of the upcoming state.
    prod_ready_d = (state_d == RUN);
    res_valid_d  = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      mode_q       <= MODE_ADD;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      prod_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      mode_q       <= mode_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      prod_ready_q <= prod_ready_d;
      res_valid_q  <= res_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign prod_ready = prod_ready_q;
  assign res_valid  = res_valid_q;
  assign res_data   = acc_q;
  assign res_ovf    = ovf_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator (ACC_W=17 so overflow is reachable); honours MAC_ACC_SAT_EN.
module tb_mac_accumulator;

  localparam int DW = 16;
  localparam int AW = 17;
  localparam int LW = 8;
`ifdef MAC_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] data;
    logic          ovf;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          sub_mode = 1'b0;
  logic          abort = 1'b0;
  logic          prod_valid = 1'b0;
  logic [DW-1:0] prod_data = '0;
  logic          prod_ready;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [AW-1:0] res_data;
  logic          res_ovf;
  logic          busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  res_t exp_q[$];
  logic [DW-1:0] prods[256];

  mac_accumulator #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .sub_mode   (sub_mode),
    .abort      (abort),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .prod_ready (prod_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_ovf    (res_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic over the whole burst.
  function automatic res_t model(input logic m, input int n);
    res_t   r;
    longint a   = 0;
    longint lim = longint'(1) << AW;
    longint p;
    r.ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      p = longint'(prods[i]);
      if (!m) begin
        a = a + p;
        if (a >= lim) begin
          r.ovf = 1'b1;
          a = SAT ? lim - 1 : a - lim;
        end
      end else if (p > a) begin
        r.ovf = 1'b1;
        a = SAT ? 0 : a - p + lim;
      end else begin
        a = a - p;
      end
    end
    r.data = AW'(a);
    return r;
  endfunction

  task automatic send_burst(input logic m, input int n, input int gapmax, input int rdly);
    res_t r;
    int   k;
    r = model(m, n);
    exp_q.push_back(r);
    res_ready = (rdly == 0);
    start = 1'b1; len = LW'(n); sub_mode = m;
    tick();
    start = 1'b0;
    if (n == 0) check("zero-len prod_ready", prod_ready, 0);
    for (int i = 0; i < n; i++) begin
      prod_valid = 1'b0;
      if (gapmax > 0) repeat ($urandom_range(0, gapmax)) tick();
      prod_valid = 1'b1;
      prod_data  = prods[i];
      for (k = 0; k < 50 && !prod_ready; k++) tick();
      if (!prod_ready) check("prod_ready timeout", prod_ready, 1);
      if (i == n - 1) check("res_valid early", res_valid, 0);
      tick();
    end
    prod_valid = 1'b0;
    check("res_valid latency", res_valid, 1);
    for (int i = 0; i < rdly; i++) begin
      start = 1'b1; len = LW'(5);
      check("res_data hold", res_data, r.data);
      check("res_ovf hold", res_ovf, r.ovf);
      tick();
    end
    start = 1'b0;
    res_ready = 1'b1;
    tick();
    check("idle after accept busy", busy, 0);
    check("idle after accept res_valid", res_valid, 0);
  endtask

  // Monitor: pops the scoreboard on every result handshake.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (rst && res_valid && res_ready) begin
        if (exp_q.size() == 0) check("unexpected result", res_valid, 0);
        else begin
          r = exp_q.pop_front();
          check("res_data", res_data, r.data);
          check("res_ovf", res_ovf, r.ovf);
        end
      end
    end
  end

  initial begin
    #1;
    check("reset res_valid", res_valid, 0);
    check("reset res_data", res_data, 0);
    check("reset res_ovf", res_ovf, 0);
    check("reset prod_ready", prod_ready, 0);
    check("reset busy", busy, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    prods[0] = 6; prods[1] = 20; prods[2] = 100;
    send_burst(1'b0, 3, 0, 0);
    send_burst(1'b0, 0, 0, 0);
    prods[0] = 16'hFFFF; prods[1] = 16'hFFFF; prods[2] = 16'hFFFF;
    send_burst(1'b0, 3, 0, 0);
    prods[0] = 5;
    send_burst(1'b1, 1, 0, 0);
    prods[0] = 300; prods[1] = 45; prods[2] = 1000; prods[3] = 7;
    send_burst(1'b0, 4, 3, 5);

    // Reset in the middle of a burst.
    res_ready = 1'b1;
    start = 1'b1; len = LW'(3); sub_mode = 1'b0;
    tick();
    start = 1'b0;
    prod_valid = 1'b1; prod_data = 16'd11;
    tick();
    prod_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midreset res_valid", res_valid, 0);
    check("midreset res_data", res_data, 0);
    check("midreset res_ovf", res_ovf, 0);
    check("midreset prod_ready", prod_ready, 0);
    check("midreset busy", busy, 0);
    tick();
    rst = 1'b1;
    prod_valid = 1'b1; prod_data = 16'd99;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post-reset prod_ready", prod_ready, 0);
    end
    prod_valid = 1'b0;
    prods[0] = 7;
    send_burst(1'b0, 1, 0, 0);

    // Abort while a result is pending.
    res_ready = 1'b0;
    start = 1'b1; len = LW'(1); sub_mode = 1'b1;
    tick();
    start = 1'b0;
    prod_valid = 1'b1; prod_data = 16'd9;
    tick();
    prod_valid = 1'b0;
    check("pre-abort res_valid", res_valid, 1);
    check("pre-abort res_ovf", res_ovf, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort res_valid", res_valid, 0);
    check("abort busy", busy, 0);
    check("abort res_data", res_data, 0);
    check("abort res_ovf", res_ovf, 0);

    for (int b = 0; b < 25; b++) begin
      int n;
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++)
        prods[i] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(60000, 65535)) : DW'($urandom);
      send_burst(1'($urandom_range(0, 1)), n, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    tick();
    check("scoreboard empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
